// File: rtl/dbg_port_master.sv
// rtl/dbg_port_master.sv - debug-port command master: command FIFO feeding a req/gnt/rvalid debug slave port
// Optional per-phase timeout is compiled in with DBG_PORT_MASTER_TIMEOUT_EN.
module dbg_port_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [14:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_we_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        debug_req_o,
    input  logic        debug_gnt_i,
    input  logic        debug_rvalid_i,
    output logic [14:0] debug_addr_o,
    output logic        debug_we_o,
    output logic [31:0] debug_wdata_o,
    input  logic [31:0] debug_rdata_i,
    output logic        busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT_RV = 2'd2;
    localparam logic [1:0] ST_RSP     = 2'd3;

    logic [14:0]      fifo_addr_q  [FIFO_DEPTH];
    logic             fifo_we_q    [FIFO_DEPTH];
    logic [31:0]      fifo_wdata_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic [1:0]  state_q, state_d;
    logic [14:0] addr_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        push, pop, tmo_hit;

    assign cmd_ready_o = (count_q < DEPTH_C);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = (state_q == ST_IDLE) && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q]  <= cmd_addr_i;
            fifo_we_q[wr_ptr_q]    <= cmd_we_i;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

`ifdef DBG_PORT_MASTER_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Restarts on every phase change so REQ and WAIT_RV each get the full budget.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tmo_cnt_q <= '0;
        end else if (state_d != state_q) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_REQ || state_q == ST_WAIT_RV) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign rsp_err_o = err_q;
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^{16'(TIMEOUT_CYCLES), err_q};
    assign rsp_err_o  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (debug_gnt_i) begin
                    state_d = ST_WAIT_RV;
                end else if (tmo_hit) begin
                    state_d = ST_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT_RV: begin
                if (debug_rvalid_i) begin
                    state_d = ST_RSP;
                    rdata_d = we_q ? 32'h0 : debug_rdata_i;
                    err_d   = 1'b0;
                end else if (tmo_hit) begin
                    state_d = ST_RSP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (pop) begin
                addr_q  <= fifo_addr_q[rd_ptr_q];
                we_q    <= fifo_we_q[rd_ptr_q];
                wdata_q <= fifo_wdata_q[rd_ptr_q];
            end
        end
    end

    assign debug_req_o   = (state_q == ST_REQ);
    assign debug_addr_o  = addr_q;
    assign debug_we_o    = we_q;
    assign debug_wdata_o = wdata_q;
    assign rsp_valid_o   = (state_q == ST_RSP);
    assign rsp_we_o      = we_q;
    assign rsp_rdata_o   = rdata_q;
    assign busy_o        = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbg_port_master.sv
// tb/tb_dbg_port_master.sv - directed self-checking bench for dbg_port_master
module tb_dbg_port_master;
    logic        clk_i, rstn_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [14:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        debug_req_o, debug_gnt_i, debug_rvalid_i, debug_we_o;
    logic [14:0] debug_addr_o;
    logic [31:0] debug_wdata_o, debug_rdata_i;
    logic        busy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    int          gnt_delay       = 0;
    bit          never_grant     = 0;
    bit          hold_rvalid     = 0;
    int          spur_req        = 0;
    int          spur_done       = 0;
    bit          pend            = 0;
    int          req_cnt         = 0;
    int          last_req_cycles = 0;
    int          req_unstable    = 0;
    logic [47:0] req_seen;
    logic [47:0] slv_log[$];

    int          rdy_mode  = 0;
    logic [33:0] rsp_q[$];
    logic [33:0] held, cur;
    bit          held_v    = 0;
    int          stab_errs = 0;

    int base, lb, stab0;

    logic        b_we   [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [14:0] b_addr [6] = '{15'h0100, 15'h0011, 15'h7FFF, 15'h7FFF, 15'h0000, 15'h1234};
    logic [31:0] b_wd   [6] = '{32'h1111_1111, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hCAFE_F00D};
    logic [31:0] b_exp  [6] = '{32'h0, 32'hC0DE_0011, 32'h0, 32'hC0DE_7FFF, 32'hC0DE_0000, 32'h0};

    dbg_port_master #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_we_o(rsp_we_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .debug_req_o(debug_req_o), .debug_gnt_i(debug_gnt_i), .debug_rvalid_i(debug_rvalid_i),
        .debug_addr_o(debug_addr_o), .debug_we_o(debug_we_o), .debug_wdata_o(debug_wdata_o),
        .debug_rdata_i(debug_rdata_i), .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [14:0] a);
        if (a == 15'h2000) return 32'h1234_5678;
        return 32'hC0DE_0000 | {17'h0, a};
    endfunction

    // Slave model: grants after gnt_delay+1 request cycles, completes one cycle later.
    initial begin
        debug_gnt_i = 1'b0; debug_rvalid_i = 1'b0; debug_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            debug_gnt_i = 1'b0; debug_rvalid_i = 1'b0;
            if (!rstn_i) begin
                pend = 0; req_cnt = 0;
            end else if (pend) begin
                if (!hold_rvalid) begin
                    debug_rvalid_i = 1'b1;
                    debug_rdata_i  = req_seen[47] ? 32'hFFFF_FFFF : rd_val(req_seen[46:32]);
                    pend = 0;
                end
            end else if (debug_req_o) begin
                if (req_cnt == 0) req_seen = {debug_we_o, debug_addr_o, debug_wdata_o};
                else if (req_seen !== {debug_we_o, debug_addr_o, debug_wdata_o}) req_unstable++;
                req_cnt++;
                if (!never_grant && req_cnt > gnt_delay) begin
                    debug_gnt_i = 1'b1; pend = 1;
                    slv_log.push_back(req_seen);
                    last_req_cycles = req_cnt; req_cnt = 0;
                end
            end else begin
                if (req_cnt != 0) begin last_req_cycles = req_cnt; req_cnt = 0; end
                if (spur_req != spur_done) begin
                    debug_rvalid_i = 1'b1; debug_rdata_i = 32'h5A5A_5A5A; spur_done++;
                end
            end
        end
    end

    // Response collector; also tracks field stability while a response is stalled.
    initial begin
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            case (rdy_mode)
                0:       rsp_ready_i = 1'b0;
                1:       rsp_ready_i = 1'b1;
                default: rsp_ready_i = ~rsp_ready_i;
            endcase
            if (!rstn_i) begin held_v = 0; continue; end
            cur = {rsp_we_o, rsp_err_o, rsp_rdata_o};
            if (rsp_valid_o && held_v && cur !== held) stab_errs++;
            if (rsp_valid_o && rsp_ready_i) begin rsp_q.push_back(cur); held_v = 0; end
            else if (rsp_valid_o) begin held = cur; held_v = 1; end
            else held_v = 0;
        end
    end

    task automatic push_cmd(input logic we, input logic [14:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = a; cmd_wdata_i = d;
        while (!cmd_ready_o && n < 500) begin @(negedge clk_i); n++; end
        if (n >= 500) check_eq("push_ready", cmd_ready_o, 1);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int t = 0;
        while (rsp_q.size() < n && t < 2000) begin @(negedge clk_i); t++; end
        if (t >= 2000) check_eq("rsp_wait", rsp_q.size(), n);
    endtask

    initial begin
        rstn_i = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_cmd_ready", cmd_ready_o, 1);
        check_eq("rst_req", debug_req_o, 0);
        check_eq("rst_rsp_valid", rsp_valid_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_rdata", rsp_rdata_o, 0);
        check_eq("rst_err", rsp_err_o, 0);
        check_eq("rst_addr", debug_addr_o, 0);
        check_eq("rst_wdata", debug_wdata_o, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Zero-wait write: request one cycle after push, response handshake at E4
        rdy_mode = 1;
        base = rsp_q.size();
        push_cmd(1'b1, 15'h0000, 32'hDEAD_BEEF);
        check_eq("wr_req_before_pop", debug_req_o, 0);
        check_eq("wr_busy", busy_o, 1);
        @(negedge clk_i);
        check_eq("wr_req", debug_req_o, 1);
        check_eq("wr_addr", debug_addr_o, 15'h0000);
        check_eq("wr_we", debug_we_o, 1);
        check_eq("wr_wdata", debug_wdata_o, 32'hDEAD_BEEF);
        @(negedge clk_i);
        check_eq("wr_req_drop", debug_req_o, 0);
        @(negedge clk_i);
        check_eq("wr_rsp_valid", rsp_valid_o, 1);
        check_eq("wr_rsp_fields", {rsp_we_o, rsp_err_o, rsp_rdata_o}, {1'b1, 1'b0, 32'h0});
        @(negedge clk_i);
        check_eq("wr_rsp_done", rsp_valid_o, 0);
        check_eq("wr_rsp_count", rsp_q.size(), base + 1);
        check_eq("wr_req_cycles", last_req_cycles, 1);

        // Read with delayed grant
        gnt_delay = 2;
        base = rsp_q.size();
        push_cmd(1'b0, 15'h2000, 32'h0);
        wait_rsp(base + 1);
        repeat (10) @(negedge clk_i);
        check_eq("rd_rsp_count", rsp_q.size(), base + 1);
        check_eq("rd_req_cycles", last_req_cycles, 3);
        check_eq("rd_req_stable", req_unstable, 0);
        check_eq("rd_rsp", rsp_q[base], {1'b0, 1'b0, 32'h1234_5678});
        gnt_delay = 0;

        // Burst of 6 with responses stalled
        rdy_mode = 0;
        base = rsp_q.size();
        lb   = slv_log.size();
        for (int i = 0; i < 5; i++) push_cmd(b_we[i], b_addr[i], b_wd[i]);
        check_eq("burst_full", cmd_ready_o, 0);
        repeat (6) @(negedge clk_i);
        check_eq("burst_still_full", cmd_ready_o, 0);
        check_eq("burst_rsp_stall", rsp_valid_o, 1);
        check_eq("burst_no_rsp", rsp_q.size(), base);
        rdy_mode = 1;
        push_cmd(b_we[5], b_addr[5], b_wd[5]);
        wait_rsp(base + 6);
        repeat (3) @(negedge clk_i);
        check_eq("burst_rsp_count", rsp_q.size(), base + 6);
        for (int i = 0; i < 6; i++) begin
            check_eq("burst_rsp", rsp_q[base + i], {b_we[i], 1'b0, b_exp[i]});
            check_eq("burst_order", slv_log[lb + i], {b_we[i], b_addr[i], b_wd[i]});
        end

        // Toggling rsp_ready during 3 reads
        rdy_mode = 2;
        stab0 = stab_errs;
        base = rsp_q.size();
        for (int i = 1; i <= 3; i++) push_cmd(1'b0, 15'(i), 32'h0);
        wait_rsp(base + 3);
        repeat (10) @(negedge clk_i);
        check_eq("tog_rsp_count", rsp_q.size(), base + 3);
        check_eq("tog_stable", stab_errs - stab0, 0);
        check_eq("tog_rsp0", rsp_q[base],     {1'b0, 1'b0, 32'hC0DE_0001});
        check_eq("tog_rsp1", rsp_q[base + 1], {1'b0, 1'b0, 32'hC0DE_0002});
        check_eq("tog_rsp2", rsp_q[base + 2], {1'b0, 1'b0, 32'hC0DE_0003});
        rdy_mode = 1;

        // Spurious rvalid while idle
        repeat (2) @(negedge clk_i);
        base = rsp_q.size();
        spur_req++;
        repeat (10) @(negedge clk_i);
        check_eq("spur_no_rsp", rsp_q.size(), base);
        check_eq("spur_valid", rsp_valid_o, 0);
        check_eq("spur_busy", busy_o, 0);

`ifdef DBG_PORT_MASTER_TIMEOUT_EN
        never_grant = 1;
        base = rsp_q.size();
        push_cmd(1'b0, 15'h0444, 32'h0);
        wait_rsp(base + 1);
        repeat (2) @(negedge clk_i);
        check_eq("tmo_req_cycles", last_req_cycles, 8);
        check_eq("tmo_rsp", rsp_q[base], {1'b0, 1'b1, 32'h0});
        never_grant = 0;
        repeat (2) @(negedge clk_i);
`endif

        // Reset while in WAIT_RV with two commands queued
        hold_rvalid = 1;
        base = rsp_q.size();
        push_cmd(1'b0, 15'h0050, 32'h0);
        push_cmd(1'b1, 15'h0060, 32'h6666_6666);
        push_cmd(1'b0, 15'h0070, 32'h0);
        check_eq("wrv_busy", busy_o, 1);
        check_eq("wrv_req", debug_req_o, 0);
        check_eq("wrv_valid", rsp_valid_o, 0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b0;
        #1;
        check_eq("wrv_rst_ready", cmd_ready_o, 1);
        check_eq("wrv_rst_busy", busy_o, 0);
        check_eq("wrv_rst_valid", rsp_valid_o, 0);
        check_eq("wrv_rst_outs", {debug_addr_o, debug_we_o, debug_wdata_o, rsp_we_o, rsp_rdata_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        hold_rvalid = 0;
        repeat (10) @(negedge clk_i);
        check_eq("wrv_no_rsp", rsp_q.size(), base);
        check_eq("wrv_idle_busy", busy_o, 0);
        check_eq("wrv_idle_req", debug_req_o, 0);

        // Reset during REQ drops debug_req_o without a clock edge
        never_grant = 1;
        base = rsp_q.size();
        push_cmd(1'b1, 15'h0123, 32'hAAAA_5555);
        @(negedge clk_i);
        check_eq("areq_req", debug_req_o, 1);
        rstn_i = 1'b0;
        #1;
        check_eq("areq_req_drop", debug_req_o, 0);
        check_eq("areq_busy", busy_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
        never_grant = 0;
        repeat (5) @(negedge clk_i);
        check_eq("areq_no_rsp", rsp_q.size(), base);
        check_eq("areq_idle", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
